// File: rtl/l2_req_arbiter_pkg.sv
// Shared cache-side bus types and arbiter state encoding for the L1-to-L2 request path.
package cache_def;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ARB_OFFSET_W = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              rw;
        logic              valid;
    } mem_req_type;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ready;
    } mem_data_type;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              valid;
    } evict_data_type;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_type;

endpackage

// File: rtl/l2_req_arbiter_evict_fifo.sv
// Eviction buffer: power-of-two circular FIFO; a push while full is taken only alongside a pop.
module arb_evict_fifo
    import cache_def::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           i_push,
    input  evict_data_type i_data,
    input  logic           i_pop,
    output evict_data_type o_data,
    output logic           o_full,
    output logic           o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    evict_data_type   r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/l2_req_arbiter.sv
// Round-robin arbiter of NUM_REQ L1 requesters onto one L2 port, plus a merged eviction stream.
// Define ARB_EVICT_FIFO_EN to buffer evictions in an EVICT_DEPTH-entry FIFO; otherwise pass-through.
module l2_req_arbiter
    import cache_def::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned OFFSET_W    = ARB_OFFSET_W,
    parameter int unsigned EVICT_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  mem_req_type    [NUM_REQ-1:0] req_i,
    output mem_data_type   [NUM_REQ-1:0] resp_o,
    output mem_req_type                  l2_req_o,
    input  mem_data_type                 l2_resp_i,
    input  evict_data_type [NUM_REQ-1:0] evict_i,
    output logic           [NUM_REQ-1:0] evict_ready_o,
    output evict_data_type               evict_o,
    input  logic                         evict_ready_i,
    output logic   [$clog2(NUM_REQ)-1:0] grant_o
);

    localparam int unsigned       GRANT_W   = $clog2(NUM_REQ);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << OFFSET_W) - ADDR_W'(1));

    arb_state_type                r_state;
    mem_req_type                  r_l2_req;
    mem_data_type [NUM_REQ-1:0]   r_resp;
    logic         [GRANT_W-1:0]   r_grant;
    logic         [GRANT_W-1:0]   r_last_grant;
    logic         [NUM_REQ-1:0]   w_req_valid;
    logic         [GRANT_W-1:0]   w_pick;
    logic                         w_ev_any;
    logic         [GRANT_W-1:0]   w_ev_sel;
    logic                         w_ev_rdy;

    // First valid index at or after last+1, wrapping; the descending loop lets the nearest win.
    function automatic logic [GRANT_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                   input logic [GRANT_W-1:0] last);
        int unsigned idx;
        rr_pick = last;
        for (int unsigned i = NUM_REQ; i >= 1; i--) begin
            idx = (32'(last) + i) % NUM_REQ;
            if (valid[idx]) begin
                rr_pick = GRANT_W'(idx);
            end
        end
    endfunction

    always_comb begin
        w_req_valid = '0;
        for (int n = 0; n < int'(NUM_REQ); n++) begin
            w_req_valid[n] = req_i[n].valid;
        end
    end

    assign w_pick = rr_pick(w_req_valid, r_last_grant);

    // RESP lasts exactly one cycle and never arbitrates, giving the requester time to drop valid.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_l2_req     <= '0;
            r_resp       <= '0;
            r_grant      <= '0;
            r_last_grant <= GRANT_W'(NUM_REQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req_valid) begin
                        r_l2_req.addr  <= req_i[w_pick].addr & ADDR_MASK;
                        r_l2_req.data  <= req_i[w_pick].data;
                        r_l2_req.rw    <= req_i[w_pick].rw;
                        r_l2_req.valid <= 1'b1;
                        r_grant        <= w_pick;
                        r_last_grant   <= w_pick;
                        r_state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (l2_resp_i.ready) begin
                        r_l2_req.valid       <= 1'b0;
                        r_resp[r_grant].data  <= l2_resp_i.data;
                        r_resp[r_grant].ready <= 1'b1;
                        r_state              <= RESP;
                    end
                end
                RESP: begin
                    r_resp  <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign l2_req_o = r_l2_req;
    assign resp_o   = r_resp;
    assign grant_o  = r_grant;

    // Fixed priority for evictions: lowest valid index is served.
    always_comb begin
        w_ev_any = 1'b0;
        w_ev_sel = '0;
        for (int n = int'(NUM_REQ) - 1; n >= 0; n--) begin
            if (evict_i[n].valid) begin
                w_ev_any = 1'b1;
                w_ev_sel = GRANT_W'(n);
            end
        end
    end

`ifdef ARB_EVICT_FIFO_EN
    evict_data_type w_fifo_head;
    logic           w_fifo_full;
    logic           w_fifo_empty;

    arb_evict_fifo #(
        .DEPTH (EVICT_DEPTH)
    ) u_evict_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_ev_any && w_ev_rdy),
        .i_data  (evict_i[w_ev_sel]),
        .i_pop   (evict_ready_i),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_ev_rdy = !w_fifo_full || evict_ready_i;
    assign evict_o  = (rst_ni && !w_fifo_empty) ? w_fifo_head : '0;
`else
    assign w_ev_rdy = evict_ready_i;
    assign evict_o  = (rst_ni && w_ev_any) ? evict_i[w_ev_sel] : '0;
`endif

    always_comb begin
        evict_ready_o = '0;
        if (rst_ni && w_ev_any && w_ev_rdy) begin
            evict_ready_o[w_ev_sel] = 1'b1;
        end
    end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Bench for l2_req_arbiter (NUM_REQ=2): directed tables, corner sequences and a random run vs a model.
module tb_l2_req_arbiter;
    import cache_def::*;

    localparam int unsigned NR    = 2;
    localparam int unsigned DEPTH = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    mem_req_type    [NR-1:0] req;
    mem_data_type   [NR-1:0] resp;
    mem_req_type             l2_req;
    mem_data_type            l2_resp;
    evict_data_type [NR-1:0] ev;
    logic           [NR-1:0] ev_rdy;
    evict_data_type          ev_o;
    logic                    ev_rdy_i;
    logic           [0:0]    gnt;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state
    int                    m_phase;
    int                    m_last;
    mem_req_type           exp_req;
    mem_data_type [NR-1:0] exp_resp;
    logic         [0:0]    exp_grant;
    evict_data_type        q[$];
    logic         [NR-1:0] ev_seen;

    always #5 clk = ~clk;

    l2_req_arbiter #(
        .NUM_REQ     (NR),
        .OFFSET_W    (4),
        .EVICT_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .resp_o        (resp),
        .l2_req_o      (l2_req),
        .l2_resp_i     (l2_resp),
        .evict_i       (ev),
        .evict_ready_o (ev_rdy),
        .evict_o       (ev_o),
        .evict_ready_i (ev_rdy_i),
        .grant_o       (gnt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ev_sel();
        for (int n = 0; n < int'(NR); n++) begin
            if (ev[n].valid) return n;
        end
        return -1;
    endfunction

    task automatic ev_expect(output logic [NR-1:0] r, output evict_data_type o);
        int s;
        s = ev_sel();
        r = '0;
        o = '0;
        if (!rst_n) return;
`ifdef ARB_EVICT_FIFO_EN
        if (s >= 0 && (q.size() < int'(DEPTH) || ev_rdy_i)) r[s] = 1'b1;
        if (q.size() != 0) o = q[0];
`else
        if (s >= 0) begin
            if (ev_rdy_i) r[s] = 1'b1;
            o = ev[s];
        end
`endif
    endtask

    // Advance the model by one rising edge using the inputs held across it.
    task automatic model_edge();
        logic [NR-1:0]  r;
        evict_data_type o;
        int             g;
        ev_expect(r, o);
`ifdef ARB_EVICT_FIFO_EN
        if (!rst_n) q.delete();
        else begin
            if (ev_rdy_i && q.size() != 0) void'(q.pop_front());
            if (|r) q.push_back(ev[ev_sel()]);
        end
`endif
        if (!rst_n) begin
            m_phase   = 0;
            m_last    = NR - 1;
            exp_req   = '0;
            exp_resp  = '0;
            exp_grant = '0;
        end else if (m_phase == 0) begin
            g = -1;
            for (int d = int'(NR); d >= 1; d--) begin
                if (req[(m_last + d) % NR].valid) g = (m_last + d) % NR;
            end
            if (g >= 0) begin
                exp_req.addr  = (req[g].addr >> 4) << 4;
                exp_req.data  = req[g].data;
                exp_req.rw    = req[g].rw;
                exp_req.valid = 1'b1;
                exp_grant     = 1'(g);
                m_last        = g;
                m_phase       = 1;
            end
        end else if (m_phase == 1) begin
            if (l2_resp.ready) begin
                exp_req.valid = 1'b0;
                exp_resp[exp_grant] = '{data: l2_resp.data, ready: 1'b1};
                m_phase = 2;
            end
        end else begin
            exp_resp = '0;
            m_phase  = 0;
        end
    endtask

    task automatic check_all();
        logic [NR-1:0]  r;
        evict_data_type o;
        chk("l2_req", l2_req, exp_req);
        chk("grant", gnt, exp_grant);
        for (int n = 0; n < int'(NR); n++) chk($sformatf("resp%0d", n), resp[n], exp_resp[n]);
        ev_expect(r, o);
        chk("evict_ready", ev_rdy, r);
        chk("evict_o", ev_o, o);
    endtask

    task automatic tick();
        #1;
        ev_seen = ev_rdy;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        req     = '0;
        l2_resp = '0;
        ev      = '0;
    endtask

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic [31:0] l2data;
        logic [31:0] exp_addr;
    } txn_t;

    typedef struct {
        logic       v0;
        logic       v1;
        logic       rdy;
        logic [1:0] exp_rdy;
        int         src;
    } evv_t;

    initial begin
        txn_t tbl[4];
        int   rise_cyc, ready_cyc, waited, acc, s0;
`ifndef ARB_EVICT_FIFO_EN
        evv_t etbl[6];
        evict_data_type e_exp;
`endif
        tbl[0] = '{1, 32'h0000_123C, 32'h0000_0011, 1'b0, 32'hA5A5_A5A5, 32'h0000_1230};
        tbl[1] = '{0, 32'hFFFF_FFFF, 32'h0000_0022, 1'b1, 32'h5A5A_0001, 32'hFFFF_FFF0};
        tbl[2] = '{1, 32'h0000_0008, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000};
        tbl[3] = '{0, 32'h8000_0010, 32'h0000_0033, 1'b0, 32'hDEAD_BEEF, 32'h8000_0010};

        rst_n    = 1'b0;
        ev_rdy_i = 1'b0;
        clear_inputs();
        tick();
        tick();
        chk("reset_l2_req", l2_req, 0);
        chk("reset_grant", gnt, 0);
        rst_n = 1'b1;
        tick();

        // Directed single transactions: address alignment and response routing
        foreach (tbl[i]) begin
            clear_inputs();
            req[tbl[i].idx] = '{addr: tbl[i].addr, data: tbl[i].data, rw: tbl[i].rw, valid: 1'b1};
            tick();
            chk("tbl_addr", l2_req.addr, tbl[i].exp_addr);
            chk("tbl_valid", l2_req.valid, 1);
            chk("tbl_grant", gnt, tbl[i].idx);
            tick();
            tick();
            l2_resp = '{data: tbl[i].l2data, ready: 1'b1};
            tick();
            l2_resp.ready = 1'b0;
            chk("tbl_resp", resp[tbl[i].idx], {tbl[i].l2data, 1'b1});
            chk("tbl_resp_other", resp[1 - tbl[i].idx], 0);
            req[tbl[i].idx].valid = 1'b0;
            tick();
            chk("tbl_resp_gone", resp[tbl[i].idx].ready, 0);
            tick();
        end

        // Eviction path
`ifdef ARB_EVICT_FIFO_EN
        clear_inputs();
        ev_rdy_i = 1'b0;
        ev[0] = '{addr: 32'h100, data: 32'h1000, valid: 1'b1};
        ev[1] = '{addr: 32'h200, data: 32'h2000, valid: 1'b1};
        #1;
        chk("fifo_first_src", ev_rdy, 2'b01);
        acc = 0;
        s0  = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            acc += $countones(ev_seen);
            if (ev_seen[0]) begin
                s0++;
                ev[0].data  = ev[0].data + 32'd1;
                ev[0].valid = (s0 < 2);
            end
            if (ev_seen[1]) ev[1].data = ev[1].data + 32'd1;
        end
        #1;
        chk("fifo_accepts", acc, 4);
        chk("fifo_full_ready", ev_rdy, 0);
        ev_rdy_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("fifo_stream_valid", ev_o.valid, 1);
            if (ev_seen[1]) ev[1].data = ev[1].data + 32'd1;
            #1;
            chk("fifo_stream_ready", ev_rdy, 2'b10);
        end
        ev = '0;
        for (int c = 0; c < 6; c++) tick();
        chk("fifo_drained", ev_o.valid, 0);
`else
        etbl[0] = '{1'b1, 1'b1, 1'b1, 2'b01, 0};
        etbl[1] = '{1'b1, 1'b1, 1'b0, 2'b00, 0};
        etbl[2] = '{1'b0, 1'b1, 1'b1, 2'b10, 1};
        etbl[3] = '{1'b0, 1'b0, 1'b1, 2'b00, -1};
        etbl[4] = '{1'b1, 1'b0, 1'b1, 2'b01, 0};
        etbl[5] = '{1'b0, 1'b1, 1'b0, 2'b00, 1};
        foreach (etbl[i]) begin
            ev[0] = '{addr: $urandom, data: $urandom, valid: etbl[i].v0};
            ev[1] = '{addr: $urandom, data: $urandom, valid: etbl[i].v1};
            ev_rdy_i = etbl[i].rdy;
            #1;
            e_exp = (etbl[i].src < 0) ? '0 : ev[etbl[i].src];
            chk("evt_ready", ev_rdy, etbl[i].exp_rdy);
            chk("evt_data", ev_o, e_exp);
        end
        ev = '0;
        ev_rdy_i = 1'b0;
        tick();
`endif

        // Requester drops valid while BUSY: response still issued, no second request
        clear_inputs();
        req[0] = '{addr: 32'h4444_0004, data: 32'h1, rw: 1'b1, valid: 1'b1};
        tick();
        chk("drop_valid_req", l2_req.valid, 1);
        req[0].valid = 1'b0;
        tick();
        tick();
        l2_resp = '{data: 32'h0000_0077, ready: 1'b1};
        tick();
        l2_resp.ready = 1'b0;
        chk("drop_resp", resp[0], {32'h0000_0077, 1'b1});
        tick();
        tick();
        tick();
        chk("drop_no_rereq", l2_req.valid, 0);

        // Both requesters held: alternating grants, 3 cycles from L2 ready to next request
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req[0] = '{addr: 32'h10, data: 32'hA, rw: 1'b0, valid: 1'b1};
        req[1] = '{addr: 32'h20, data: 32'hB, rw: 1'b1, valid: 1'b1};
        ready_cyc = 0;
        for (int t = 0; t < 4; t++) begin
            waited = 0;
            while (!l2_req.valid && waited < 10) begin
                tick();
                waited++;
            end
            if (!l2_req.valid) begin
                chk("alt_timeout", 0, 1);
                break;
            end
            rise_cyc = cyc;
            chk("alt_grant", gnt, t % 2);
            if (t > 0) chk("alt_gap", rise_cyc - ready_cyc, 3);
            tick();
            tick();
            ready_cyc = cyc;
            l2_resp = '{data: 32'(t + 100), ready: 1'b1};
            tick();
            l2_resp.ready = 1'b0;
        end

        // Reset mid-transaction, then index 0 must win first
        clear_inputs();
        while (m_phase != 0) tick();
        req[1] = '{addr: 32'h30, data: 32'hC, rw: 1'b0, valid: 1'b1};
        tick();
        rst_n = 1'b0;
        tick();
        chk("rst_l2_req", l2_req, 0);
        chk("rst_resp", resp, 0);
        chk("rst_grant", gnt, 0);
        chk("rst_evict", {ev_o, ev_rdy}, 0);
        rst_n = 1'b1;
        req = '0;
        tick();
        chk("rst_idle", l2_req.valid, 0);
        req[0] = '{addr: 32'h40, data: 32'hD, rw: 1'b0, valid: 1'b1};
        req[1] = '{addr: 32'h50, data: 32'hE, rw: 1'b0, valid: 1'b1};
        tick();
        chk("rst_first_grant", gnt, 0);
        chk("rst_first_addr", l2_req.addr, 32'h40);

        // Random traffic against the model
        clear_inputs();
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < int'(NR); n++) begin
                if (!req[n].valid || $urandom_range(3) == 0) begin
                    req[n] = '{addr: $urandom, data: $urandom, rw: 1'($urandom_range(1)),
                               valid: 1'($urandom_range(1))};
                end
                if (!ev[n].valid || ev_seen[n]) begin
                    ev[n] = '{addr: $urandom, data: $urandom, valid: 1'($urandom_range(1))};
                end
            end
            l2_resp  = '{data: $urandom, ready: ($urandom_range(2) == 0)};
            ev_rdy_i = 1'($urandom_range(1));
            rst_n    = ($urandom_range(80) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
